// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD transmit path.
// Nibble mode in the writer is selected by LCD_4BIT_EN.
package lcd_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    PULSE = ST_PULSE,
    HOLD  = ST_HOLD,
    WAIT  = ST_WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME2 = 8'h03;

  // Clear and return-home take far longer to execute
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == LCD_CMD_CLEAR ||
                   data == LCD_CMD_HOME  ||
                   data == LCD_CMD_HOME2);
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter shared by every bus phase.
// done is high whenever the count sits at zero.
module lcd_cycle_timer #(
  parameter int CNT_W = 17
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780-style bus writer with valid/ready request side.
// Define LCD_4BIT_EN to send each byte as two nibbles.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 2,
  parameter int WAIT_SHORT_CYC = 2000,
  parameter int WAIT_LONG_CYC  = 80000,
  parameter int CNT_W          = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic       REQ_RS,
  input  logic [7:0] REQ_DATA,
  output logic       REQ_READY,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] LD_SETUP =
    CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_E =
    CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD =
    CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SHORT =
    CNT_W'(WAIT_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG =
    CNT_W'(WAIT_LONG_CYC - 1);

  lcd_state_e       state;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] wait_val;
  logic             done;
  logic             long_wait;

`ifdef LCD_4BIT_EN
  logic       nib;
  logic [3:0] lo_nib;
`endif

  assign accept   = REQ_VALID && REQ_READY &&
                    (state == IDLE);
  assign wait_val = long_wait ? LD_LONG : LD_SHORT;
  assign LCD_RW   = 1'b0;

  always_comb begin
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: begin
        load     = accept;
        load_val = LD_SETUP;
      end
      SETUP: begin
        load     = done;
        load_val = LD_E;
      end
      PULSE: begin
        load     = done;
        load_val = LD_HOLD;
      end
      HOLD: begin
        load = done;
`ifdef LCD_4BIT_EN
        load_val = nib ? wait_val : LD_SETUP;
`else
        load_val = wait_val;
`endif
      end
      default: ;
    endcase
  end

  lcd_cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (load),
    .load_val(load_val),
    .done    (done)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
      REQ_READY <= 1'b0;
      BUSY      <= 1'b1;
      long_wait <= 1'b0;
`ifdef LCD_4BIT_EN
      nib       <= 1'b0;
      lo_nib    <= 4'h0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            LCD_RS    <= REQ_RS;
            REQ_READY <= 1'b0;
            BUSY      <= 1'b1;
            long_wait <= is_long_cmd(REQ_RS, REQ_DATA);
`ifdef LCD_4BIT_EN
            LCD_DATA  <= {REQ_DATA[7:4], 4'h0};
            lo_nib    <= REQ_DATA[3:0];
            nib       <= 1'b0;
`else
            LCD_DATA  <= REQ_DATA;
`endif
          end else begin
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end
        SETUP: begin
          if (done) begin
            state <= PULSE;
            LCD_E <= 1'b1;
          end
        end
        PULSE: begin
          if (done) begin
            state <= HOLD;
            LCD_E <= 1'b0;
          end
        end
        HOLD: begin
          if (done) begin
`ifdef LCD_4BIT_EN
            // Second nibble reuses the full setup/pulse/hold run
            if (!nib) begin
              state    <= SETUP;
              nib      <= 1'b1;
              LCD_DATA <= {lo_nib, 4'h0};
            end else begin
              state <= WAIT;
              nib   <= 1'b0;
            end
`else
            state <= WAIT;
`endif
          end
        end
        WAIT: begin
          if (done) begin
            state     <= IDLE;
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboarded bench for lcd_bus_writer, short timing params.
// Build with LCD_4BIT_EN to exercise nibble mode.
module tb_lcd_bus_writer;

  localparam int S  = 1;
  localparam int EH = 3;
  localparam int H  = 1;
  localparam int WS = 5;
  localparam int WL = 20;
  localparam int P  = S + EH + H;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_RS = 1'b0;
  logic [7:0] REQ_DATA = 8'h00;
  logic       REQ_READY;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t sb_x;
  logic e_prev = 1'b0;

  lcd_bus_writer #(
    .SETUP_CYC     (S),
    .E_HIGH_CYC    (EH),
    .HOLD_CYC      (H),
    .WAIT_SHORT_CYC(WS),
    .WAIT_LONG_CYC (WL),
    .CNT_W         (17)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ_VALID(REQ_VALID),
    .REQ_RS   (REQ_RS),
    .REQ_DATA (REQ_DATA),
    .REQ_READY(REQ_READY),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_DATA (LCD_DATA),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // Bus-side monitor: every E rise pops one expected beat
  always @(negedge CLK) begin
    if (!RESET && LCD_E && !e_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: E pulse rs=%0b data=%02h, none expected",
                 LCD_RS, LCD_DATA);
      end else begin
        sb_x = sb.pop_front();
        if ({LCD_RS, LCD_DATA} !== {sb_x.rs, sb_x.d}) begin
          errors++;
          $display("FAIL sb_beat: got rs=%0b data=%02h want rs=%0b data=%02h",
                   LCD_RS, LCD_DATA, sb_x.rs, sb_x.d);
        end
      end
    end
    e_prev = LCD_E;
  end

  task automatic push_exp(input logic rs, input logic [7:0] d);
`ifdef LCD_4BIT_EN
    sb.push_back('{rs: rs, d: {d[7:4], 4'h0}});
    sb.push_back('{rs: rs, d: {d[3:0], 4'h0}});
`else
    sb.push_back('{rs: rs, d: d});
`endif
  endtask

  // Called on a negedge; returns just after the accept edge
  task automatic accept(input logic rs, input logic [7:0] d);
    for (int i = 0; i < 200 && REQ_READY !== 1'b1; i++)
      @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: ready=%0b want 1", REQ_READY);
    end
    REQ_VALID = 1'b1;
    REQ_RS    = rs;
    REQ_DATA  = d;
    @(posedge CLK);
    push_exp(rs, d);
  endtask

  // Walks one transaction cycle by cycle from the accept edge
  task automatic check_txn(
    input logic       rs,
    input logic [7:0] d,
    input int         w,
    input logic       vmid,
    input logic       nrs,
    input logic [7:0] nd,
    input logic       vend
  );
    int   total;
    logic ee;
    logic er;
    logic [7:0] ed;
`ifdef LCD_4BIT_EN
    total = 2 * P + w;
`else
    total = P + w;
`endif
    #1;
    REQ_VALID = vmid;
    REQ_RS    = nrs;
    REQ_DATA  = nd;
    for (int k = 0; k <= total; k++) begin
      @(negedge CLK);
      ee = (k >= S && k < S + EH);
      ed = d;
`ifdef LCD_4BIT_EN
      ee = ee || (k >= P + S && k < P + S + EH);
      ed = (k < P) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
`endif
      er = (k == total);
      checks++;
      if (LCD_E !== ee) begin
        errors++;
        $display("FAIL e_timing k=%0d: got %0b want %0b", k, LCD_E, ee);
      end
      checks++;
      if ({LCD_RW, LCD_RS, LCD_DATA} !== {1'b0, rs, ed}) begin
        errors++;
        $display("FAIL bus k=%0d: rw/rs/data=%0b/%0b/%02h want 0/%0b/%02h",
                 k, LCD_RW, LCD_RS, LCD_DATA, rs, ed);
      end
      checks++;
      if ({REQ_READY, BUSY} !== {er, !er}) begin
        errors++;
        $display("FAIL ready k=%0d: ready/busy=%0b/%0b want %0b/%0b",
                 k, REQ_READY, BUSY, er, !er);
      end
      if (k == total - 1) REQ_VALID = vend;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    checks++;
    if ({LCD_E, LCD_RS, LCD_RW, LCD_DATA, REQ_READY, BUSY} !==
        {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s: e/rs/rw/data/ready/busy=%0b/%0b/%0b/%02h/%0b/%0b want 0/0/0/00/0/1",
               tag, LCD_E, LCD_RS, LCD_RW, LCD_DATA, REQ_READY, BUSY);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_reset_outs("reset_vals");
    RESET = 1'b0;
    #1;
    check_reset_outs("pre_first_edge");
    @(negedge CLK);
    checks++;
    if ({REQ_READY, BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL ready_after_reset: ready/busy=%0b/%0b want 1/0",
               REQ_READY, BUSY);
    end
  endtask

  task automatic test_data_write;
    logic [7:0] last;
    accept(1'b1, 8'h41);
    check_txn(1'b1, 8'h41, WS, 1'b0, 1'b0, 8'hFF, 1'b0);
`ifdef LCD_4BIT_EN
    last = 8'h10;
`else
    last = 8'h41;
`endif
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({LCD_RS, LCD_DATA, REQ_READY} !== {1'b1, last, 1'b1}) begin
      errors++;
      $display("FAIL idle_hold: rs/data/ready=%0b/%02h/%0b want 1/%02h/1",
               LCD_RS, LCD_DATA, REQ_READY, last);
    end
  endtask

  task automatic test_commands;
    accept(1'b0, 8'h01);
    check_txn(1'b0, 8'h01, WL, 1'b0, 1'b0, 8'h00, 1'b0);
    accept(1'b0, 8'h06);
    check_txn(1'b0, 8'h06, WS, 1'b0, 1'b0, 8'h00, 1'b0);
    accept(1'b0, 8'h02);
    check_txn(1'b0, 8'h02, WL, 1'b0, 1'b0, 8'h00, 1'b0);
    accept(1'b0, 8'h03);
    check_txn(1'b0, 8'h03, WL, 1'b0, 1'b0, 8'h00, 1'b0);
    accept(1'b0, 8'h00);
    check_txn(1'b0, 8'h00, WS, 1'b0, 1'b0, 8'h00, 1'b0);
    accept(1'b1, 8'h01);
    check_txn(1'b1, 8'h01, WS, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // VALID pulsed while busy must not start anything
  task automatic test_ignore_busy;
    accept(1'b1, 8'hA5);
    check_txn(1'b1, 8'hA5, WS, 1'b1, 1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({REQ_READY, LCD_E} !== 2'b10) begin
        errors++;
        $display("FAIL ignore_busy: ready/e=%0b/%0b want 1/0",
                 REQ_READY, LCD_E);
      end
    end
  endtask

  task automatic test_back_to_back;
    accept(1'b0, 8'h38);
    check_txn(1'b0, 8'h38, WS, 1'b1, 1'b0, 8'h0C, 1'b1);
    @(posedge CLK);
    push_exp(1'b0, 8'h0C);
    check_txn(1'b0, 8'h0C, WS, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid;
    accept(1'b1, 8'h55);
    #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (LCD_E !== 1'b1) begin
      errors++;
      $display("FAIL e_before_reset: got %0b want 1", LCD_E);
    end
    RESET = 1'b1;
    #1;
    check_reset_outs("async_reset");
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    @(negedge CLK);
    checks++;
    if ({REQ_READY, BUSY, LCD_E} !== 3'b100) begin
      errors++;
      $display("FAIL ready_after_mid_reset: ready/busy/e=%0b/%0b/%0b want 1/0/0",
               REQ_READY, BUSY, LCD_E);
    end
    accept(1'b0, 8'h30);
    check_txn(1'b0, 8'h30, WS, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_commands();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d beats never seen, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
